// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port 0) and DMA (port 1).
// One transaction at a time; reads wait out the fixed memory latency, writes are posted.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrData,
    output logic              mem_rdMem,
    output logic              mem_wrMem,
    input  logic [DATA_W-1:0] mem_rdData
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StCap} state_e;

    localparam logic [3:0] CntLast = 4'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              accept;
    logic              sel;
    logic              sel_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        sel     = 1'b0;

        // Port 0 wins when alone, or on contention when port 1 was served last.
        if (reset && state_q == StIdle) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                accept = 1'b1;
                sel    = 1'b0;
            end else if (req1_valid) begin
                accept = 1'b1;
                sel    = 1'b1;
            end
        end
        sel_we = sel ? req1_we : req0_we;

        case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (accept) state_d = sel_we ? StWr : StRd;
            end
            StWr: state_d = StIdle;
            StRd: begin
                if (cnt_q == CntLast) begin
                    state_d = StCap;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                last_grant_q <= sel;
                grant_q      <= sel;
                addr_q       <= sel ? req1_addr : req0_addr;
                // Write data only tracks writes so mem_wrData stays put across reads.
                if (sel_we) wdata_q <= sel ? req1_wdata : req0_wdata;
            end
            rvalid0_q <= (state_q == StCap) && !grant_q;
            rvalid1_q <= (state_q == StCap) && grant_q;
            if (state_q == StCap) begin
                if (grant_q) rdata1_q <= mem_rdData;
                else         rdata0_q <= mem_rdData;
            end
        end
    end

    assign req0_ready  = accept && !sel;
    assign req1_ready  = accept && sel;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign mem_addr    = addr_q;
    assign mem_wrData  = wdata_q;
    assign mem_rdMem   = (state_q == StRd);
    assign mem_wrMem   = (state_q == StWr);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: default READ_LAT=2 instance plus a READ_LAT=3 instance,
// each attached to a small BRAM-plus-output-register memory model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A (READ_LAT=2)
    logic        r0v = 0, r0we = 0, r1v = 0, r1we = 0;
    logic [31:0] r0a = 0, r0d = 0, r1a = 0, r1d = 0;
    logic        rdy0, rdy1, rv0, rv1, rdmem, wrmem;
    logic [31:0] rd0, rd1, maddr, mwdata, mrdata;

    data_mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_we(r0we), .req0_addr(r0a), .req0_wdata(r0d),
        .req0_ready(rdy0), .req0_rvalid(rv0), .req0_rdata(rd0),
        .req1_valid(r1v), .req1_we(r1we), .req1_addr(r1a), .req1_wdata(r1d),
        .req1_ready(rdy1), .req1_rvalid(rv1), .req1_rdata(rd1),
        .mem_addr(maddr), .mem_wrData(mwdata), .mem_rdMem(rdmem), .mem_wrMem(wrmem),
        .mem_rdData(mrdata)
    );

    logic [31:0] mem_a [0:255];
    logic [31:0] pipe_a [0:1];
    logic        loaded_a = 1'b0;
    always @(posedge clk) begin
        if (!loaded_a) begin
            mem_a[8'h10] <= 32'hDEADBEEF;
            loaded_a     <= 1'b1;
        end
        if (wrmem) mem_a[maddr[7:0]] <= mwdata;
        if (rdmem) begin
            pipe_a[0] <= mem_a[maddr[7:0]];
            pipe_a[1] <= pipe_a[0];
        end
    end
    assign mrdata = pipe_a[1];

    // Instance B (READ_LAT=3)
    logic        b_r0v = 0;
    logic [31:0] b_r0a = 0;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_rdmem, b_wrmem;
    logic [31:0] b_rd0, b_rd1, b_maddr, b_mwdata, b_mrdata;

    data_mem_arbiter #(.READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(b_r0v), .req0_we(1'b0), .req0_addr(b_r0a), .req0_wdata(32'h0),
        .req0_ready(b_rdy0), .req0_rvalid(b_rv0), .req0_rdata(b_rd0),
        .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(32'h0), .req1_wdata(32'h0),
        .req1_ready(b_rdy1), .req1_rvalid(b_rv1), .req1_rdata(b_rd1),
        .mem_addr(b_maddr), .mem_wrData(b_mwdata), .mem_rdMem(b_rdmem), .mem_wrMem(b_wrmem),
        .mem_rdData(b_mrdata)
    );

    logic [31:0] mem_b [0:255];
    logic [31:0] pipe_b [0:2];
    logic        loaded_b = 1'b0;
    always @(posedge clk) begin
        if (!loaded_b) begin
            mem_b[8'h30] <= 32'hCAFEF00D;
            loaded_b     <= 1'b1;
        end
        if (b_wrmem) mem_b[b_maddr[7:0]] <= b_mwdata;
        if (b_rdmem) begin
            pipe_b[0] <= mem_b[b_maddr[7:0]];
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end
    assign b_mrdata = pipe_b[2];

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        r0v = 0; r1v = 0; b_r0v = 0;
        #1;
        tests_run++;
        if ({rdy0, rdy1, rv0, rv1} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: got %b required 0000", {rdy0, rdy1, rv0, rv1});
        end
        tests_run++;
        if ({rd0, rd1} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h %h required 0 0", rd0, rd1);
        end
        tests_run++;
        if ({maddr, mwdata, rdmem, wrmem} !== 66'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: addr %h wdata %h rd %b wr %b required all 0",
                     maddr, mwdata, rdmem, wrmem);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        r0v = 1; r0we = 0; r0a = 32'h10;
        #1;
        tests_run++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_accept: ready0 %b ready1 %b required 1 0", rdy0, rdy1);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            r0v = 0;
            #1;
            tests_run++;
            if (rdmem !== (c <= 2) || rv0 !== (c == 4) || wrmem !== 1'b0) begin
                tests_failed++;
                $display("FAIL rd_timing c=%0d: rdMem %b rvalid0 %b wrMem %b required %b %b 0",
                         c, rdmem, rv0, wrmem, c <= 2, c == 4);
            end
            if (c <= 2) begin
                tests_run++;
                if (maddr !== 32'h10) begin
                    tests_failed++;
                    $display("FAIL rd_addr c=%0d: got %h required 00000010", c, maddr);
                end
            end
            if (c >= 4) begin
                tests_run++;
                if (rd0 !== 32'hDEADBEEF) begin
                    tests_failed++;
                    $display("FAIL rd_data c=%0d: got %h required deadbeef", c, rd0);
                end
            end
        end
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        r1v = 1; r1we = 1; r1a = 32'h20; r1d = 32'h12345678;
        #1;
        tests_run++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_accept: ready1 %b ready0 %b required 1 0", rdy1, rdy0);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            r1v = 0;
            #1;
            tests_run++;
            if (wrmem !== (c == 1) || rdmem !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL wr_timing c=%0d: wrMem %b rdMem %b rv0 %b rv1 %b required %b 0 0 0",
                         c, wrmem, rdmem, rv0, rv1, c == 1);
            end
            if (c == 1) begin
                tests_run++;
                if (maddr !== 32'h20 || mwdata !== 32'h12345678) begin
                    tests_failed++;
                    $display("FAIL wr_fields: addr %h data %h required 00000020 12345678",
                             maddr, mwdata);
                end
            end
        end
        @(negedge clk);
        r1v = 1; r1we = 0; r1a = 32'h20;
        #1;
        tests_run++;
        if (rdy1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rb_accept: ready1 %b required 1", rdy1);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            r1v = 0;
            #1;
            tests_run++;
            if (rv1 !== (c == 4) || rv0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rb_rvalid c=%0d: rvalid1 %b rvalid0 %b required %b 0",
                         c, rv1, rv0, c == 4);
            end
        end
        tests_run++;
        if (rd1 !== 32'h12345678 || rd0 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL rb_data: rdata1 %h rdata0 %h required 12345678 deadbeef", rd1, rd0);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c < 8) begin
                r0v = 1; r0we = 1;
                r0a = 32'h40 + 32'(c / 2);
                r0d = 32'hA0000000 + 32'(c / 2);
            end else begin
                r0v = 0;
            end
            #1;
            tests_run++;
            if (rdy0 !== ((c < 8) && (c % 2 == 0)) || wrmem !== (c % 2 == 1) || rdmem !== 1'b0)
            begin
                tests_failed++;
                $display("FAIL b2b c=%0d: ready0 %b wrMem %b rdMem %b required %b %b 0",
                         c, rdy0, wrmem, rdmem, (c < 8) && (c % 2 == 0), c % 2 == 1);
            end
            if (c % 2 == 1) begin
                tests_run++;
                if (maddr !== 32'h40 + 32'(c / 2) || mwdata !== 32'hA0000000 + 32'(c / 2)) begin
                    tests_failed++;
                    $display("FAIL b2b_fields c=%0d: addr %h data %h required %h %h", c, maddr,
                             mwdata, 32'h40 + 32'(c / 2), 32'hA0000000 + 32'(c / 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        r1v = 1; r1we = 0; r1a = 32'h20;
        #1;
        tests_run++;
        if (rdy1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_accept: ready1 %b required 1", rdy1);
        end
        @(negedge clk);
        r1v = 0;
        #1;
        tests_run++;
        if (rdmem !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_rd: rdMem %b required 1", rdmem);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (rdmem !== 1'b0 || wrmem !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async: rdMem %b wrMem %b required 0 0", rdmem, wrmem);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (rv1 !== 1'b0 || rdmem !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_no_rvalid c=%0d: rvalid1 %b rdMem %b required 0 0",
                         c, rv1, rdmem);
            end
        end
        @(negedge clk);
        r0v = 1; r0we = 0; r0a = 32'h10;
        r1v = 1; r1we = 0; r1a = 32'h20;
        #1;
        tests_run++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_first_grant: ready0 %b ready1 %b required 1 0", rdy0, rdy1);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            r0v = 0; r1v = 0;
        end
        #1;
        tests_run++;
        if (rv0 !== 1'b1 || rd0 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL mid_after: rvalid0 %b rdata0 %h required 1 deadbeef", rv0, rd0);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int t = 0; t <= 16; t++) begin
            int phase;
            int k;
            logic g;
            logic pg;
            @(negedge clk);
            r0v = (t < 16); r0we = 0; r0a = 32'h10;
            r1v = (t < 16); r1we = 0; r1a = 32'h20;
            #1;
            phase = t % 4;
            k     = t / 4;
            g     = 1'(k % 2);
            pg    = 1'((k + 1) % 2);
            tests_run++;
            if (rdy0 !== ((t < 16) && phase == 0 && !g) || rdy1 !== ((t < 16) && phase == 0 && g))
            begin
                tests_failed++;
                $display("FAIL cont_grant t=%0d: ready0 %b ready1 %b required %b %b", t, rdy0,
                         rdy1, (t < 16) && phase == 0 && !g, (t < 16) && phase == 0 && g);
            end
            tests_run++;
            if (rv0 !== (t >= 4 && phase == 0 && !pg) || rv1 !== (t >= 4 && phase == 0 && pg))
            begin
                tests_failed++;
                $display("FAIL cont_rvalid t=%0d: rvalid0 %b rvalid1 %b required %b %b", t, rv0,
                         rv1, t >= 4 && phase == 0 && !pg, t >= 4 && phase == 0 && pg);
            end
            if (t >= 4 && phase == 0) begin
                tests_run++;
                if ((!pg && rd0 !== 32'hDEADBEEF) || (pg && rd1 !== 32'h12345678)) begin
                    tests_failed++;
                    $display("FAIL cont_data t=%0d: rdata0 %h rdata1 %h required port%0d data",
                             t, rd0, rd1, pg);
                end
            end
        end
    endtask

    task automatic test_read_lat3();
        @(negedge clk);
        b_r0v = 1; b_r0a = 32'h30;
        #1;
        tests_run++;
        if (b_rdy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat3_accept: ready0 %b required 1", b_rdy0);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            b_r0v = 0;
            #1;
            tests_run++;
            if (b_rdmem !== (c <= 3) || b_rv0 !== (c == 5) || b_rv1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL lat3_timing c=%0d: rdMem %b rvalid0 %b rvalid1 %b required %b %b 0",
                         c, b_rdmem, b_rv0, b_rv1, c <= 3, c == 5);
            end
        end
        tests_run++;
        if (b_rd0 !== 32'hCAFEF00D || b_rdy1 !== 1'b0 || b_wrmem !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_data: rdata0 %h ready1 %b wrMem %b required cafef00d 0 0",
                     b_rd0, b_rdy1, b_wrmem);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_back_to_back();
        test_reset_mid_read();
        test_contention();
        test_read_lat3();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Round-robin arbiter that shares the single-port data memory between two requesters: port 0 is the CPU load/store stage and port 1 is the DMA/loader. It accepts one request at a time and drives the memory's addr/wrData/rdMem/wrMem controls. It sequences the memory's fixed multi-cycle read latency (synchronous BRAM plus output register) and returns read data with a one-cycle valid pulse to the granted requester. Writes are posted and produce no response.

Parameters:
ADDR_W, 32, width of request and memory address
DATA_W, 32, width of read and write data
READ_LAT, 2, cycles from the first cycle of mem_addr/mem_rdMem presentation until mem_rdData is valid; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 request pending; held with fields stable until accepted
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle (valid & ready)
req0_rvalid  out  1  one-cycle pulse, req0_rdata valid
req0_rdata  out  DATA_W  port 0 read data
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as port 0, for port 1
mem_addr  out  ADDR_W  to data memory addr
mem_wrData  out  DATA_W  to data memory wrData
mem_rdMem  out  1  to data memory rdMem
mem_wrMem  out  1  to data memory wrMem
mem_rdData  in  DATA_W  from data memory rdData

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; last_grant=1, so port 0 wins the first contention; all ready/rvalid outputs 0; reqX_rdata=0; mem_addr=0, mem_wrData=0, mem_rdMem=0, mem_wrMem=0; latency counter=0.
- FSM states: IDLE, WR, RD, CAP.
- IDLE: reqX_ready is combinational and asserted for at most one port.
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - On accept: latch we/addr/wdata into internal registers, update last_grant, then go to WR if we=1, else RD.
  - ready is 0 in every state other than IDLE.
- WR (1 cycle): mem_wrMem=1; mem_addr and mem_wrData come from the latched registers. Go to IDLE. No rvalid is generated.
- RD (READ_LAT cycles): mem_rdMem=1; mem_addr is held from the latched register; counter runs 0..READ_LAT-1. After the last count, go to CAP.
- CAP (1 cycle): mem_rdMem=0, so the memory output register holds its value. At the closing edge, load mem_rdData into the granted port's rdata register, pulse that port's rvalid for the next cycle, and go to IDLE.
- mem_rdMem and mem_wrMem are never both 1. Outside WR and RD both are 0, and mem_addr/mem_wrData hold their last values.
- Timing: with accept in cycle A, a write hits memory in cycle A+1. A read drives cycles A+1..A+READ_LAT, CAP is cycle A+READ_LAT+1, and rvalid is in cycle A+READ_LAT+2. In that rvalid cycle the FSM is in IDLE and may accept a new request.
- Back-to-back throughput: at most 1 write per 2 cycles, and 1 read per READ_LAT+2 cycles.
- reqX_rdata holds its value until that port's next read completes. The other port's rdata is unaffected.
- Requester rules: the requester must not drop valid or change its fields before ready. If valid drops before ready, the request is simply not taken; this is not an error.
- Reset mid-operation: the in-flight transaction is abandoned. No rvalid is issued, and mem_rdMem/mem_wrMem deassert asynchronously. A write that completed its WR cycle is not undone.

Test Plan:
- Reset, then single read: req0 read addr=0x10 with memory[0x10]=0xDEADBEEF. Required: req0_ready in cycle A; mem_rdMem=1 for 2 cycles; req0_rvalid in cycle A+4 with req0_rdata=0xDEADBEEF.
- Write then read-back: req1 write addr=0x20 data=0x12345678. Required: mem_wrMem=1 for exactly one cycle in A+1. Then a req1 read of 0x20 returns 0x12345678; req0 sees no rvalid throughout.
- Contention: both valid continuously, all reads. Required: grants alternate 0,1,0,1 with port 0 first after reset, and each rvalid goes only to the port that issued that read.
- Back-to-back writes, port 0 only: 4 writes. Required: accepts every 2 cycles; mem_wrMem pattern 0,1,0,1,…; mem_rdMem stays 0.
- Reset asserted during the RD of a port 1 read. Required: mem_rdMem drops immediately, no req1_rvalid ever appears, and the first request after release is granted to port 0.
- READ_LAT=3 build: one read. Required: mem_rdMem high for 3 cycles and rvalid in cycle A+5.
